// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding and load-use bubble insertion.
// Feeds ALU_Control, data_1 and data_2 straight into the 16-bit ALU.
module id_ex_stage #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [2:0]        id_alu_control,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [DATA_W-1:0] id_rs1_data,
    input  logic [DATA_W-1:0] id_rs2_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic              id_use_imm,
    input  logic              id_rs2_used,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_branch,
    input  logic              flush,
    input  logic              ex_hold,
    input  logic              exmem_reg_write,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic [DATA_W-1:0] exmem_result,
    input  logic              memwb_reg_write,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic [DATA_W-1:0] memwb_result,
    output logic [2:0]        ALU_Control,
    output logic [DATA_W-1:0] data_1,
    output logic [DATA_W-1:0] data_2,
    output logic [DATA_W-1:0] ex_store_data,
    output logic              ex_valid,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_branch,
    output logic [REG_AW-1:0] ex_rd,
    output logic              stall_id
);

    logic [REG_AW-1:0] rs1_q;
    logic [REG_AW-1:0] rs2_q;
    logic [DATA_W-1:0] rs1_data_q;
    logic [DATA_W-1:0] rs2_data_q;
    logic [DATA_W-1:0] imm_q;
    logic              use_imm_q;
    logic              load_use;
    logic [DATA_W-1:0] fwd_rs1;
    logic [DATA_W-1:0] fwd_rs2;

    // A load in EX cannot forward until MEM, so a dependent ID instruction waits one cycle.
    assign load_use = ex_valid && ex_mem_read && (ex_rd != '0) && id_valid &&
                      ((id_rs1 == ex_rd) || (id_rs2_used && (id_rs2 == ex_rd)));

    // Flush kills the ID instruction, so there is nothing left to hold.
    assign stall_id = !flush && (ex_hold || load_use);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            ex_valid     <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
            ex_branch    <= 1'b0;
            ALU_Control  <= 3'b000;
            ex_rd        <= '0;
            rs1_q        <= '0;
            rs2_q        <= '0;
            rs1_data_q   <= '0;
            rs2_data_q   <= '0;
            imm_q        <= '0;
            use_imm_q    <= 1'b0;
        end else if (ex_hold) begin
            ex_valid     <= ex_valid;
            ex_reg_write <= ex_reg_write;
            ex_mem_read  <= ex_mem_read;
            ex_mem_write <= ex_mem_write;
            ex_branch    <= ex_branch;
            ALU_Control  <= ALU_Control;
            ex_rd        <= ex_rd;
            rs1_q        <= rs1_q;
            rs2_q        <= rs2_q;
            rs1_data_q   <= rs1_data_q;
            rs2_data_q   <= rs2_data_q;
            imm_q        <= imm_q;
            use_imm_q    <= use_imm_q;
        end else if (load_use) begin
            ex_valid     <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
            ex_branch    <= 1'b0;
            ALU_Control  <= 3'b000;
            ex_rd        <= '0;
            rs1_q        <= '0;
            rs2_q        <= '0;
            rs1_data_q   <= '0;
            rs2_data_q   <= '0;
            imm_q        <= '0;
            use_imm_q    <= 1'b0;
        end else begin
            ex_valid     <= id_valid;
            ex_reg_write <= id_reg_write;
            ex_mem_read  <= id_mem_read;
            ex_mem_write <= id_mem_write;
            ex_branch    <= id_branch;
            ALU_Control  <= id_alu_control;
            ex_rd        <= id_rd;
            rs1_q        <= id_rs1;
            rs2_q        <= id_rs2;
            rs1_data_q   <= id_rs1_data;
            rs2_data_q   <= id_rs2_data;
            imm_q        <= id_imm;
            use_imm_q    <= id_use_imm;
        end
    end

    // EX/MEM is the younger producer, so it wins over MEM/WB; R0 always reads zero.
    function automatic logic [DATA_W-1:0] fwd(
        input logic [REG_AW-1:0] src,
        input logic [DATA_W-1:0] raw,
        input logic              em_we,
        input logic [REG_AW-1:0] em_rd,
        input logic [DATA_W-1:0] em_res,
        input logic              mw_we,
        input logic [REG_AW-1:0] mw_rd,
        input logic [DATA_W-1:0] mw_res
    );
        logic [DATA_W-1:0] val;
        val = raw;
        if (src == '0) val = '0;
        else if (em_we && (em_rd == src)) val = em_res;
        else if (mw_we && (mw_rd == src)) val = mw_res;
        return val;
    endfunction

    always_comb begin
        fwd_rs1 = fwd(rs1_q, rs1_data_q, exmem_reg_write, exmem_rd, exmem_result,
                      memwb_reg_write, memwb_rd, memwb_result);
        fwd_rs2 = fwd(rs2_q, rs2_data_q, exmem_reg_write, exmem_rd, exmem_result,
                      memwb_reg_write, memwb_rd, memwb_result);
    end

    assign data_1        = fwd_rs1;
    assign ex_store_data = fwd_rs2;
    assign data_2        = use_imm_q ? imm_q : fwd_rs2;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, pass-through, forwarding priority, immediates,
// load-use bubbles, hold, flush and reset during a stall.
module tb_id_ex_stage;

    localparam int DATA_W = 16;
    localparam int REG_AW = 3;

    logic              clk;
    logic              rst;
    logic              id_valid;
    logic [2:0]        id_alu_control;
    logic [REG_AW-1:0] id_rs1, id_rs2, id_rd;
    logic [DATA_W-1:0] id_rs1_data, id_rs2_data, id_imm;
    logic              id_use_imm, id_rs2_used;
    logic              id_reg_write, id_mem_read, id_mem_write, id_branch;
    logic              flush, ex_hold;
    logic              exmem_reg_write, memwb_reg_write;
    logic [REG_AW-1:0] exmem_rd, memwb_rd;
    logic [DATA_W-1:0] exmem_result, memwb_result;
    logic [2:0]        ALU_Control;
    logic [DATA_W-1:0] data_1, data_2, ex_store_data;
    logic              ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch;
    logic [REG_AW-1:0] ex_rd;
    logic              stall_id;

    int checks = 0;
    int errors = 0;
    logic [18:0] exp_q[$];

    id_ex_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_alu_control(id_alu_control),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_use_imm(id_use_imm), .id_rs2_used(id_rs2_used),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_branch(id_branch),
        .flush(flush), .ex_hold(ex_hold),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .ALU_Control(ALU_Control), .data_1(data_1), .data_2(data_2),
        .ex_store_data(ex_store_data), .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_branch(ex_branch),
        .ex_rd(ex_rd), .stall_id(stall_id)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive_id(input logic v, input logic [2:0] alu,
                            input logic [REG_AW-1:0] rs1, input logic [REG_AW-1:0] rs2,
                            input logic [REG_AW-1:0] rd,
                            input logic [DATA_W-1:0] d1, input logic [DATA_W-1:0] d2,
                            input logic rs2_used, input logic rw, input logic mr);
        id_valid = v; id_alu_control = alu; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_rs1_data = d1; id_rs2_data = d2; id_rs2_used = rs2_used;
        id_reg_write = rw; id_mem_read = mr; id_mem_write = 1'b0; id_branch = 1'b0;
        id_use_imm = 1'b0; id_imm = '0;
    endtask

    task automatic drive_fwd(input logic emw, input logic [REG_AW-1:0] emr,
                             input logic [DATA_W-1:0] emv, input logic mww,
                             input logic [REG_AW-1:0] mwr, input logic [DATA_W-1:0] mwv);
        exmem_reg_write = emw; exmem_rd = emr; exmem_result = emv;
        memwb_reg_write = mww; memwb_rd = mwr; memwb_result = mwv;
    endtask

    initial begin
        // Reset with garbage on the ID and forwarding inputs
        rst = 1'b1; flush = 1'b0; ex_hold = 1'b0;
        drive_id(1'b1, 3'($urandom_range(0, 7)), 3'($urandom_range(1, 7)), 3'($urandom_range(1, 7)),
                 3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom), 1'b1, 1'b1, 1'b1);
        drive_fwd(1'b1, 3'd5, 16'hDEAD, 1'b1, 3'd6, 16'hBEEF);
        tick(); tick();
        check("rst_ex_valid", 32'(ex_valid), 0);
        check("rst_data_1", 32'(data_1), 0);
        check("rst_data_2", 32'(data_2), 0);
        check("rst_alu", 32'(ALU_Control), 0);
        check("rst_stall", 32'(stall_id), 0);
        check("rst_ctl", 32'({ex_reg_write, ex_mem_read, ex_mem_write, ex_branch}), 0);

        // Plain pass-through
        rst = 1'b0;
        drive_fwd(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
        drive_id(1'b1, 3'b001, 3'd1, 3'd2, 3'd4, 16'h0005, 16'h0003, 1'b1, 1'b1, 1'b0);
        tick();
        check("pass_data_1", 32'(data_1), 32'h0005);
        check("pass_data_2", 32'(data_2), 32'h0003);
        check("pass_alu", 32'(ALU_Control), 1);
        check("pass_valid", 32'(ex_valid), 1);
        check("pass_rd", 32'(ex_rd), 4);

        // Forwarding priority on rs1 = R2
        drive_id(1'b1, 3'b000, 3'd2, 3'd5, 3'd1, 16'h0077, 16'h0099, 1'b1, 1'b1, 1'b0);
        tick();
        drive_fwd(1'b1, 3'd2, 16'h1111, 1'b1, 3'd2, 16'h2222); settle();
        check("fwd_exmem", 32'(data_1), 32'h1111);
        check("fwd_rs2_raw", 32'(data_2), 32'h0099);
        exmem_reg_write = 1'b0; settle();
        check("fwd_memwb", 32'(data_1), 32'h2222);
        drive_fwd(1'b1, 3'd0, 16'h1111, 1'b1, 3'd0, 16'h2222); settle();
        check("fwd_rd_r0_raw", 32'(data_1), 32'h0077);
        drive_id(1'b1, 3'b000, 3'd0, 3'd5, 3'd1, 16'h5555, 16'h0099, 1'b1, 1'b1, 1'b0);
        tick();
        check("r0_reads_zero", 32'(data_1), 0);

        // Immediate operand with forwarded store data
        drive_id(1'b1, 3'b000, 3'd1, 3'd6, 3'd0, 16'h0010, 16'h0000, 1'b1, 1'b0, 1'b0);
        id_use_imm = 1'b1; id_imm = 16'hFFF0; id_mem_write = 1'b1;
        drive_fwd(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
        tick();
        drive_fwd(1'b1, 3'd6, 16'h00AA, 1'b0, 3'd0, 16'h0); settle();
        check("imm_data_2", 32'(data_2), 32'hFFF0);
        check("imm_store", 32'(ex_store_data), 32'h00AA);
        check("imm_mem_write", 32'(ex_mem_write), 1);
        drive_fwd(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);

        // Load-use on rs1: one-cycle stall, bubble, then the instruction enters
        drive_id(1'b1, 3'b000, 3'd1, 3'd0, 3'd3, 16'h0001, 16'h0000, 1'b0, 1'b1, 1'b1);
        tick();
        drive_id(1'b1, 3'b010, 3'd3, 3'd1, 3'd2, 16'h0033, 16'h0011, 1'b1, 1'b1, 1'b0);
        settle();
        check("lu_stall", 32'(stall_id), 1);
        tick();
        check("lu_bubble_valid", 32'(ex_valid), 0);
        check("lu_bubble_alu", 32'(ALU_Control), 0);
        check("lu_stall_drop", 32'(stall_id), 0);
        tick();
        check("lu_enter_valid", 32'(ex_valid), 1);
        check("lu_enter_alu", 32'(ALU_Control), 3'b010);
        check("lu_enter_rd", 32'(ex_rd), 2);

        // Load-use candidate on rs2 only counts when rs2 is used
        drive_id(1'b1, 3'b000, 3'd1, 3'd0, 3'd3, 16'h0001, 16'h0000, 1'b0, 1'b1, 1'b1);
        tick();
        drive_id(1'b1, 3'b000, 3'd1, 3'd3, 3'd2, 16'h0001, 16'h0002, 1'b0, 1'b1, 1'b0);
        settle();
        check("lu_rs2_unused", 32'(stall_id), 0);
        id_rs2_used = 1'b1; settle();
        check("lu_rs2_used", 32'(stall_id), 1);

        // Flush together with load-use: bubble, no stall
        flush = 1'b1; settle();
        check("flush_stall", 32'(stall_id), 0);
        tick();
        flush = 1'b0;
        check("flush_bubble", 32'(ex_valid), 0);
        check("flush_mem_read", 32'(ex_mem_read), 0);

        // Hold for 3 cycles keeps EX constant
        drive_id(1'b1, 3'b011, 3'd1, 3'd2, 3'd5, 16'h0123, 16'h0456, 1'b1, 1'b1, 1'b0);
        tick();
        ex_hold = 1'b1;
        drive_id(1'b1, 3'b110, 3'd4, 3'd4, 3'd7, 16'hAAAA, 16'hBBBB, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) exp_q.push_back({3'b011, 16'h0123});
        for (int i = 0; i < 3; i++) begin
            logic [18:0] e;
            settle();
            check("hold_stall", 32'(stall_id), 1);
            tick();
            e = exp_q.pop_front();
            check("hold_alu_data_1", 32'({ALU_Control, data_1}), 32'(e));
        end
        check("hold_rd", 32'(ex_rd), 5);

        // Flush during hold wins
        flush = 1'b1; settle();
        check("flush_hold_stall", 32'(stall_id), 0);
        tick();
        flush = 1'b0; ex_hold = 1'b0;
        check("flush_hold_bubble", 32'({ex_valid, ALU_Control}), 0);

        // Reset in the middle of a load-use stall
        drive_id(1'b1, 3'b000, 3'd1, 3'd0, 3'd3, 16'h0001, 16'h0000, 1'b0, 1'b1, 1'b1);
        tick();
        drive_id(1'b1, 3'b010, 3'd3, 3'd1, 3'd2, 16'h0033, 16'h0011, 1'b1, 1'b1, 1'b0);
        settle();
        check("rst_lu_stall", 32'(stall_id), 1);
        rst = 1'b1;
        tick();
        check("rst_lu_valid", 32'(ex_valid), 0);
        check("rst_lu_stall_drop", 32'(stall_id), 0);
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Guard against a hung run
    initial begin
        #100000;
        $display("FAIL timeout: got no finish, expected finish before 100000");
        $fatal(1);
    end

endmodule
